// File: rtl/cpu_clk_if.sv
// rtl/cpu_clk_if.sv - front-panel switch, halt and CPU clock signals of cpu_clk_ctrl
// CYCLE_CNT is present only when CYCLE_CNT_EN is defined.
interface cpu_clk_if;
   logic        nSTEP_SW;
   logic        nMODE_SW;
   logic        nHALT;
   logic        CPU_CLK;
   logic        CLK_EN;
   logic        RUN;
   logic        BUSY;
`ifdef CYCLE_CNT_EN
   logic [15:0] CYCLE_CNT;

   modport master (output nSTEP_SW, nMODE_SW, nHALT,
                   input  CPU_CLK, CLK_EN, RUN, BUSY, CYCLE_CNT);
   modport slave  (input  nSTEP_SW, nMODE_SW, nHALT,
                   output CPU_CLK, CLK_EN, RUN, BUSY, CYCLE_CNT);
`else
   modport master (output nSTEP_SW, nMODE_SW, nHALT,
                   input  CPU_CLK, CLK_EN, RUN, BUSY);
   modport slave  (input  nSTEP_SW, nMODE_SW, nHALT,
                   output CPU_CLK, CLK_EN, RUN, BUSY);
`endif
endinterface

// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - step/run CPU clock generator driven by the debounced front-panel switches
// Optional CPU clock cycle counter enabled by macro CYCLE_CNT_EN.
module cpu_clk_ctrl #(
   parameter int PULSE_LEN    = 4,
   parameter int RUN_DIV_BITS = 5
) (
   input  logic      CLK_33,
   input  logic      nRST,
   cpu_clk_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   localparam logic [7:0] PHASE_LOAD = 8'(PULSE_LEN - 1);

   state_t                  state, state_nxt;
   logic [7:0]              phase, phase_nxt;
   logic [RUN_DIV_BITS-1:0] presc;
   logic [2:0]              step_sync, mode_sync, halt_sync;
   logic                    run_q, cpu_clk_q, clk_en_q;
   logic                    cpu_clk_nxt, clk_en_nxt;
   logic                    step_press, mode_press, tick, trigger;

   // bit 0 is the first flop; a press is the 1->0 transition between the last two
   assign step_press = step_sync[2] & ~step_sync[1];
   assign mode_press = mode_sync[2] & ~mode_sync[1];
   assign tick       = &presc;
   assign trigger    = run_q ? (tick & halt_sync[2]) : step_press;

   always_ff @(posedge CLK_33) begin
      if (!nRST) begin
         step_sync <= 3'b111;
         mode_sync <= 3'b111;
         halt_sync <= 3'b111;
         presc     <= '0;
         run_q     <= 1'b0;
      end else begin
         step_sync <= {step_sync[1:0], bus.nSTEP_SW};
         mode_sync <= {mode_sync[1:0], bus.nMODE_SW};
         halt_sync <= {halt_sync[1:0], bus.nHALT};
         presc     <= presc + 1'b1;
         if (mode_press)
            run_q <= ~run_q;
      end
   end

   always_ff @(posedge CLK_33) begin
      if (!nRST) begin
         state     <= IDLE;
         phase     <= '0;
         cpu_clk_q <= 1'b0;
         clk_en_q  <= 1'b0;
      end else begin
         state     <= state_nxt;
         phase     <= phase_nxt;
         cpu_clk_q <= cpu_clk_nxt;
         clk_en_q  <= clk_en_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      phase_nxt  = phase;
      clk_en_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) begin
               state_nxt  = HIGH;
               phase_nxt  = PHASE_LOAD;
               clk_en_nxt = 1'b1;
            end
         end
         HIGH: begin
            if (phase == 8'd0) begin
               state_nxt = LOW;
               phase_nxt = PHASE_LOAD;
            end else begin
               phase_nxt = phase - 8'd1;
            end
         end
         LOW: begin
            if (phase == 8'd0)
               state_nxt = IDLE;
            else
               phase_nxt = phase - 8'd1;
         end
         default: state_nxt = IDLE;
      endcase
      // CPU_CLK is a flop copy of the next state so it never glitches
      cpu_clk_nxt = (state_nxt == HIGH);
   end

   assign bus.CPU_CLK = cpu_clk_q;
   assign bus.CLK_EN  = clk_en_q;
   assign bus.RUN     = run_q;
   assign bus.BUSY    = (state != IDLE);

`ifdef CYCLE_CNT_EN
   logic [15:0] cycle_cnt;

   always_ff @(posedge CLK_33) begin
      if (!nRST)
         cycle_cnt <= '0;
      else if (clk_en_nxt)
         cycle_cnt <= cycle_cnt + 16'd1;
   end

   assign bus.CYCLE_CNT = cycle_cnt;
`endif
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb/tb_cpu_clk_ctrl.sv - self-checking bench for cpu_clk_ctrl against a pulse-age reference model
module tb_cpu_clk_ctrl;
   localparam int PL     = 4;
   localparam int DB     = 5;
   localparam int PERIOD = 1 << DB;

   logic clk = 1'b0;
   logic rstn;
   int   n_checks = 0;
   int   n_fails  = 0;

   cpu_clk_if bus();

   cpu_clk_ctrl #(.PULSE_LEN(PL), .RUN_DIV_BITS(DB)) dut (
      .CLK_33 (clk),
      .nRST   (rstn),
      .bus    (bus)
   );

   always #15 clk = ~clk;

   // Reference: pulse described by its age in cycles since CLK_EN; prescaler as a modulo count
   logic       h_step[3], h_mode[3], h_halt[3];
   bit         m_run;
   int         m_age;
   int         m_presc;
   int         m_cnt;
   logic [3:0] m_exp = 4'b0000;
   logic [3:0] obs;

   assign obs = {bus.CPU_CLK, bus.CLK_EN, bus.RUN, bus.BUSY};

   always @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < 3; i++) begin
            h_step[i] = 1'b1;
            h_mode[i] = 1'b1;
            h_halt[i] = 1'b1;
         end
         m_run   = 1'b0;
         m_age   = 2 * PL;
         m_presc = 0;
         m_cnt   = 0;
      end else begin
         bit sp, mp, trig;
         sp   = h_step[2] && !h_step[1];
         mp   = h_mode[2] && !h_mode[1];
         trig = (m_age >= 2 * PL) &&
                (m_run ? (m_presc == PERIOD - 1 && h_halt[2] == 1'b1) : sp);
         if (trig) begin
            m_age = 0;
            m_cnt = (m_cnt + 1) % 65536;
         end else if (m_age < 2 * PL) begin
            m_age++;
         end
         if (mp)
            m_run = !m_run;
         m_presc = (m_presc + 1) % PERIOD;
         for (int i = 2; i > 0; i--) begin
            h_step[i] = h_step[i-1];
            h_mode[i] = h_mode[i-1];
            h_halt[i] = h_halt[i-1];
         end
         h_step[0] = bus.nSTEP_SW;
         h_mode[0] = bus.nMODE_SW;
         h_halt[0] = bus.nHALT;
      end
      m_exp = {m_age < PL, m_age == 0, m_run, m_age < 2 * PL};
   end

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== 4'b0000) begin
            n_fails++;
            $display("FAIL reset_hold cyc=%0d got=%b want=0000", k, obs);
         end
         bus.nSTEP_SW = ~bus.nSTEP_SW;
         bus.nMODE_SW = ~bus.nMODE_SW;
      end
      bus.nSTEP_SW = 1'b1;
      bus.nMODE_SW = 1'b1;
      rstn = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== 4'b0000 || obs !== m_exp) begin
            n_fails++;
            $display("FAIL reset_after cyc=%0d got=%b want=0000", k, obs);
         end
      end
   endtask

   task automatic test_single_step();
      int       en_cnt = 0;
      logic [3:0] want;
      idle_cycles(10);
      bus.nSTEP_SW = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         want = {(k >= 3 && k <= 6), (k == 3), 1'b0, (k >= 3 && k <= 10)};
         if (bus.CLK_EN === 1'b1) en_cnt++;
         n_checks++;
         if (obs !== want || obs !== m_exp) begin
            n_fails++;
            $display("FAIL single_step edge=%0d got=%b want=%b model=%b", k, obs, want, m_exp);
         end
      end
      n_checks++;
      if (en_cnt !== 1) begin
         n_fails++;
         $display("FAIL single_step_count got=%0d want=1", en_cnt);
      end
      bus.nSTEP_SW = 1'b1;
      idle_cycles(10);
   endtask

   task automatic test_step_dropped();
      int en_cnt = 0;
      bus.nSTEP_SW = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.CLK_EN === 1'b1) en_cnt++;
         n_checks++;
         if (obs !== m_exp) begin
            n_fails++;
            $display("FAIL step_dropped edge=%0d got=%b want=%b", k, obs, m_exp);
         end
         if (k == 3)  bus.nSTEP_SW = 1'b1;
         if (k == 4)  bus.nSTEP_SW = 1'b0;
         if (k == 15) bus.nSTEP_SW = 1'b1;
      end
      n_checks++;
      if (en_cnt !== 1) begin
         n_fails++;
         $display("FAIL step_dropped_count got=%0d want=1", en_cnt);
      end
      idle_cycles(10);
   endtask

   task automatic test_run_mode();
      bit         found = 0;
      logic [3:0] want;
      bus.nHALT    = 1'b1;
      bus.nMODE_SW = 1'b0;
      idle_cycles(4);
      bus.nMODE_SW = 1'b1;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (bus.RUN === 1'b1) found = 1;
      end
      n_checks++;
      if (!found) begin
         n_fails++;
         $display("FAIL run_enter got=%b want=1", bus.RUN);
      end
      found = 0;
      for (int k = 0; k < 2 * PERIOD && !found; k++) begin
         @(negedge clk);
         if (bus.CLK_EN === 1'b1) found = 1;
      end
      n_checks++;
      if (!found) begin
         n_fails++;
         $display("FAIL run_first_tick got=0 want=1");
      end
      for (int c = 1; c < 10 * PERIOD; c++) begin
         int j;
         @(negedge clk);
         j    = c % PERIOD;
         want = {(j < PL), (j == 0), 1'b1, (j < 2 * PL)};
         n_checks++;
         if (obs !== want || obs !== m_exp) begin
            n_fails++;
            $display("FAIL run_period c=%0d got=%b want=%b model=%b", c, obs, want, m_exp);
         end
         if (c % 3 == 0) bus.nSTEP_SW = ~bus.nSTEP_SW;
      end
      bus.nSTEP_SW = 1'b1;
   endtask

   task automatic test_halt();
      bit found = 0;
      int en_cnt = 0;
      int hi_cnt = 0;
      for (int k = 0; k < 2 * PERIOD && !found; k++) begin
         @(negedge clk);
         if (bus.CLK_EN === 1'b1) found = 1;
      end
      n_checks++;
      if (!found) begin
         n_fails++;
         $display("FAIL halt_sync_tick got=0 want=1");
      end
      bus.nHALT = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.CLK_EN === 1'b1)  en_cnt++;
         if (bus.CPU_CLK === 1'b1) hi_cnt++;
         n_checks++;
         if (obs !== m_exp) begin
            n_fails++;
            $display("FAIL halt_hold k=%0d got=%b want=%b", k, obs, m_exp);
         end
      end
      n_checks++;
      if (en_cnt !== 0 || hi_cnt !== PL - 1) begin
         n_fails++;
         $display("FAIL halt_counts got=en%0d/hi%0d want=en0/hi%0d", en_cnt, hi_cnt, PL - 1);
      end
      bus.nHALT = 1'b1;
      found = 0;
      for (int k = 0; k < PERIOD + 8 && !found; k++) begin
         @(negedge clk);
         if (bus.CLK_EN === 1'b1) found = 1;
         n_checks++;
         if (obs !== m_exp) begin
            n_fails++;
            $display("FAIL halt_resume k=%0d got=%b want=%b", k, obs, m_exp);
         end
      end
      n_checks++;
      if (!found) begin
         n_fails++;
         $display("FAIL halt_resume_tick got=0 want=1");
      end
   endtask

   task automatic test_step_halt();
      int en_cnt = 0;
      bus.nHALT    = 1'b0;
      bus.nMODE_SW = 1'b0;
      idle_cycles(4);
      bus.nMODE_SW = 1'b1;
      idle_cycles(20);
      n_checks++;
      if (bus.RUN !== 1'b0 || bus.BUSY !== 1'b0) begin
         n_fails++;
         $display("FAIL step_halt_mode got=run%b/busy%b want=run0/busy0", bus.RUN, bus.BUSY);
      end
      bus.nSTEP_SW = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.CLK_EN === 1'b1) en_cnt++;
         n_checks++;
         if (obs !== m_exp) begin
            n_fails++;
            $display("FAIL step_halt edge=%0d got=%b want=%b", k, obs, m_exp);
         end
         if (k == 20) bus.nSTEP_SW = 1'b1;
      end
      n_checks++;
      if (en_cnt !== 1) begin
         n_fails++;
         $display("FAIL step_halt_count got=%0d want=1", en_cnt);
      end
      bus.nHALT = 1'b1;
   endtask

   task automatic test_reset_mid_pulse();
      bit found = 0;
      bus.nMODE_SW = 1'b0;
      idle_cycles(4);
      bus.nMODE_SW = 1'b1;
      for (int k = 0; k < 3 * PERIOD && !found; k++) begin
         @(negedge clk);
         if (bus.CLK_EN === 1'b1 && bus.RUN === 1'b1) found = 1;
      end
      n_checks++;
      if (!found) begin
         n_fails++;
         $display("FAIL reset_mid_pulse_start got=0 want=1");
      end
      rstn = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs !== 4'b0000 || obs !== m_exp) begin
         n_fails++;
         $display("FAIL reset_mid_pulse got=%b want=0000", obs);
      end
      rstn = 1'b1;
      idle_cycles(5);
   endtask

   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== m_exp) begin
            n_fails++;
            $display("FAIL random k=%0d got=%b want=%b", k, obs, m_exp);
         end
         if ($urandom_range(0, 15) == 0) bus.nSTEP_SW = ~bus.nSTEP_SW;
         if ($urandom_range(0, 39) == 0) bus.nMODE_SW = ~bus.nMODE_SW;
         if ($urandom_range(0, 59) == 0) bus.nHALT    = ~bus.nHALT;
         rstn = ($urandom_range(0, 799) != 0);
      end
      rstn         = 1'b1;
      bus.nSTEP_SW = 1'b1;
      bus.nMODE_SW = 1'b1;
      bus.nHALT    = 1'b1;
   endtask

`ifdef CYCLE_CNT_EN
   task automatic test_cycle_cnt();
      rstn = 1'b0;
      idle_cycles(2);
      rstn = 1'b1;
      idle_cycles(5);
      repeat (3) begin
         bus.nSTEP_SW = 1'b0;
         idle_cycles(15);
         bus.nSTEP_SW = 1'b1;
         idle_cycles(15);
      end
      n_checks++;
      if (bus.CYCLE_CNT !== 16'd3 || bus.CYCLE_CNT !== 16'(m_cnt)) begin
         n_fails++;
         $display("FAIL cycle_cnt got=%0d want=3", bus.CYCLE_CNT);
      end
   endtask
`endif

   initial begin
      rstn         = 1'b0;
      bus.nSTEP_SW = 1'b1;
      bus.nMODE_SW = 1'b1;
      bus.nHALT    = 1'b1;
      test_reset();
      test_single_step();
      test_step_dropped();
      test_run_mode();
      test_halt();
      test_step_halt();
      test_reset_mid_pulse();
      test_random();
`ifdef CYCLE_CNT_EN
      test_cycle_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
